// File: rtl/bpf_stage2.sv
// ============================================================================
//  Module      : bpf_stage2
//  Description : Bad-packet filter drop controller. Pops one status byte per
//                packet, then forwards or drains the packet's data beats and
//                keeps saturating good/bad packet counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpf_stage2 #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [7:0]              AXIS_PS_TDATA,
    input  logic                    AXIS_PS_TVALID,
    output logic                    AXIS_PS_TREADY,

    input  logic [DATA_WIDTH-1:0]   AXIS_RX_TDATA,
    input  logic [DATA_WIDTH/8-1:0] AXIS_RX_TKEEP,
    input  logic                    AXIS_RX_TLAST,
    input  logic                    AXIS_RX_TUSER,
    input  logic                    AXIS_RX_TVALID,
    output logic                    AXIS_RX_TREADY,

    output logic [DATA_WIDTH-1:0]   AXIS_TX_TDATA,
    output logic [DATA_WIDTH/8-1:0] AXIS_TX_TKEEP,
    output logic                    AXIS_TX_TLAST,
    output logic                    AXIS_TX_TUSER,
    output logic                    AXIS_TX_TVALID,
    input  logic                    AXIS_TX_TREADY,

    output logic [31:0]             good_packets,
    output logic [31:0]             bad_packets,
    output logic                    busy
);

    localparam logic [1:0]  S_WAIT_STATUS = 2'd0;
    localparam logic [1:0]  S_FORWARD     = 2'd1;
    localparam logic [1:0]  S_DROP        = 2'd2;
    localparam logic [31:0] CNT_MAX       = 32'hFFFF_FFFF;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;
    logic        in_wait;
    logic        in_fwd;
    logic        in_drop;
    logic        good_done;
    logic        bad_done;
    logic        unused_bits;

    // Only bit 0 of the status byte matters; stage-1 TUSER is superseded by it.
    assign unused_bits = ^{AXIS_PS_TDATA[7:1], AXIS_RX_TUSER};

    assign in_wait   = (state == S_WAIT_STATUS);
    assign in_fwd    = (state == S_FORWARD);
    assign in_drop   = (state == S_DROP);
    assign good_done = in_fwd  && AXIS_RX_TVALID && AXIS_TX_TREADY && AXIS_RX_TLAST;
    assign bad_done  = in_drop && AXIS_RX_TVALID && AXIS_RX_TLAST;

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT_STATUS: begin
                if (AXIS_PS_TVALID) begin
                    state_next = AXIS_PS_TDATA[0] ? S_DROP : S_FORWARD;
                end
            end
            S_FORWARD: begin
                if (good_done) begin
                    state_next = S_WAIT_STATUS;
                end
            end
            S_DROP: begin
                if (bad_done) begin
                    state_next = S_WAIT_STATUS;
                end
            end
            default: state_next = S_WAIT_STATUS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_WAIT_STATUS;
            good_cnt <= 32'd0;
            bad_cnt  <= 32'd0;
        end else begin
            state <= state_next;
            if (good_done && (good_cnt != CNT_MAX)) begin
                good_cnt <= good_cnt + 32'd1;
            end
            if (bad_done && (bad_cnt != CNT_MAX)) begin
                bad_cnt <= bad_cnt + 32'd1;
            end
        end
    end

    // Status ready is held high through reset so the upstream FIFO sees a clean idle.
    assign AXIS_PS_TREADY = reset || in_wait;
    assign AXIS_RX_TREADY = !reset && ((in_fwd && AXIS_TX_TREADY) || in_drop);

    assign AXIS_TX_TDATA  = AXIS_RX_TDATA;
    assign AXIS_TX_TKEEP  = AXIS_RX_TKEEP;
    assign AXIS_TX_TLAST  = AXIS_RX_TLAST;
    assign AXIS_TX_TUSER  = 1'b0;
    assign AXIS_TX_TVALID = !reset && in_fwd && AXIS_RX_TVALID;

    assign good_packets   = good_cnt;
    assign bad_packets    = bad_cnt;
    assign busy           = !reset && !in_wait;

endmodule

`default_nettype wire

// File: tb/tb_bpf_stage2.sv
// ============================================================================
//  Module      : tb_bpf_stage2
//  Description : Self-checking bench for bpf_stage2 with FIFO-style sources and
//                a packet-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bpf_stage2;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    PS_TDATA;
    logic          PS_TVALID;
    logic          PS_TREADY;
    logic [DW-1:0] RX_TDATA;
    logic [KW-1:0] RX_TKEEP;
    logic          RX_TLAST;
    logic          RX_TUSER;
    logic          RX_TVALID;
    logic          RX_TREADY;
    logic [DW-1:0] TX_TDATA;
    logic [KW-1:0] TX_TKEEP;
    logic          TX_TLAST;
    logic          TX_TUSER;
    logic          TX_TVALID;
    logic          TX_TREADY;
    logic [31:0]   good_packets;
    logic [31:0]   bad_packets;
    logic          busy;

    always #5 clk = ~clk;

    bpf_stage2 #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .AXIS_PS_TDATA  (PS_TDATA),
        .AXIS_PS_TVALID (PS_TVALID),
        .AXIS_PS_TREADY (PS_TREADY),
        .AXIS_RX_TDATA  (RX_TDATA),
        .AXIS_RX_TKEEP  (RX_TKEEP),
        .AXIS_RX_TLAST  (RX_TLAST),
        .AXIS_RX_TUSER  (RX_TUSER),
        .AXIS_RX_TVALID (RX_TVALID),
        .AXIS_RX_TREADY (RX_TREADY),
        .AXIS_TX_TDATA  (TX_TDATA),
        .AXIS_TX_TKEEP  (TX_TKEEP),
        .AXIS_TX_TLAST  (TX_TLAST),
        .AXIS_TX_TUSER  (TX_TUSER),
        .AXIS_TX_TVALID (TX_TVALID),
        .AXIS_TX_TREADY (TX_TREADY),
        .good_packets   (good_packets),
        .bad_packets    (bad_packets),
        .busy           (busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic [7:0]  status;
        int          nbeats;
        int          exp_tx;
        logic [31:0] exp_good;
        logic [31:0] exp_bad;
    } vec_t;

    logic [7:0]  ps_q[$];
    beat_t       rx_q[$];
    beat_t       exp_q[$];
    beat_t       got_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          mode = 0;          // 0 idle, 1 forwarding, 2 dropping
    int          end_cyc = -10;
    int          ps_cyc = 0;
    bit          have_end = 0;
    bit          first_pending = 0;
    bit          strict = 0;
    bit          gaps = 0;
    int          tx_mode = 0;
    logic [31:0] serial = 32'd0;
    logic [31:0] exp_good = 32'd0;
    logic [31:0] exp_bad = 32'd0;
    logic [31:0] mon_good = 32'd0;
    logic [31:0] mon_bad = 32'd0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %b required %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%h required 0x%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic drive();
        PS_TVALID = !reset && (ps_q.size() > 0);
        PS_TDATA  = (ps_q.size() > 0) ? ps_q[0] : 8'h00;
        RX_TVALID = !reset && (rx_q.size() > 0) && (!gaps || ($urandom_range(0, 3) != 0));
        if (rx_q.size() > 0) begin
            RX_TDATA = rx_q[0].data;
            RX_TKEEP = rx_q[0].keep;
            RX_TLAST = rx_q[0].last;
        end else begin
            RX_TDATA = '0;
            RX_TKEEP = '0;
            RX_TLAST = 1'b0;
        end
        RX_TUSER = 1'($urandom_range(0, 1));
        case (tx_mode)
            1:       TX_TREADY = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       TX_TREADY = ($urandom_range(0, 3) != 0);
            default: TX_TREADY = 1'b1;
        endcase
    endtask

    task automatic send(input logic [7:0] status, input int n);
        ps_q.push_back(status);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            serial++;
            b.data = {16{serial}};
            b.keep = {$urandom(), $urandom()};
            b.last = (i == n - 1);
            rx_q.push_back(b);
            if (!status[0]) exp_q.push_back(b);
        end
        if (status[0]) exp_bad = sat_inc(exp_bad);
        else           exp_good = sat_inc(exp_good);
    endtask

    // One clock: sample and check at the falling edge, then advance the sources.
    task automatic step();
        bit ps_hs;
        bit rx_hs;
        bit tx_hs;
        @(negedge clk);
        cyc++;
        ps_hs = PS_TVALID && PS_TREADY;
        rx_hs = RX_TVALID && RX_TREADY;
        tx_hs = TX_TVALID && TX_TREADY;
        if (!reset) begin
            chk32("good_count", good_packets, mon_good);
            chk32("bad_count", bad_packets, mon_bad);
            chk1("busy", busy, mode != 0);
            if (end_cyc == cyc - 1) chk1("ps_ready_after_end", PS_TREADY, 1'b1);
            if (ps_hs) chk1("no_beat_in_status_cycle", rx_hs, 1'b0);
            if (strict && ps_hs && have_end) chk32("status_gap", cyc - end_cyc, 32'd1);
            if (strict && first_pending && rx_hs) chk32("first_beat_latency", cyc - ps_cyc, 32'd1);
            if (rx_hs) first_pending = 0;
            case (mode)
                1: begin
                    chk1("rx_ready_mirror", RX_TREADY, TX_TREADY);
                    chk1("tx_valid_mirror", TX_TVALID, RX_TVALID);
                end
                2: begin
                    chk1("drop_tx_valid", TX_TVALID, 1'b0);
                    chk1("drop_rx_ready", RX_TREADY, 1'b1);
                end
                default: begin
                    chk1("idle_ps_ready", PS_TREADY, 1'b1);
                    chk1("idle_rx_ready", RX_TREADY, 1'b0);
                    chk1("idle_tx_valid", TX_TVALID, 1'b0);
                end
            endcase
            if (tx_hs) begin
                beat_t g;
                g.data = TX_TDATA;
                g.keep = TX_TKEEP;
                g.last = TX_TLAST;
                got_q.push_back(g);
                chk1("tx_tuser", TX_TUSER, 1'b0);
            end
            if (rx_hs && RX_TLAST && mode != 0) begin
                if (mode == 1) mon_good = sat_inc(mon_good);
                else           mon_bad  = sat_inc(mon_bad);
                mode = 0;
                end_cyc = cyc;
                have_end = 1;
            end
            if (ps_hs) begin
                mode = PS_TDATA[0] ? 2 : 1;
                ps_cyc = cyc;
                first_pending = 1;
            end
        end
        @(posedge clk);
        #1;
        if (ps_hs) void'(ps_q.pop_front());
        if (rx_hs) void'(rx_q.pop_front());
        drive();
    endtask

    task automatic compare_stream(input string name);
        int n;
        chk32({name, "_beat_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].keep !== exp_q[i].keep ||
                got_q[i].last !== exp_q[i].last) begin
                n_bad++;
                $display("FAIL %s_beat[%0d]: got data 0x%h last %b required data 0x%h last %b",
                         name, i, got_q[i].data[31:0], got_q[i].last,
                         exp_q[i].data[31:0], exp_q[i].last);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run(input int budget);
        int n = 0;
        have_end = 0;
        drive();
        while ((ps_q.size() > 0 || rx_q.size() > 0 || mode != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: %0d cycles without finishing, required < %0d", n, budget);
            ps_q.delete();
            rx_q.delete();
        end
        step();
        step();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h00, 4, 4, 32'd1, 32'd0};
        vecs[1] = '{8'hFF, 3, 0, 32'd1, 32'd1};
        vecs[2] = '{8'hFE, 1, 1, 32'd2, 32'd1};
        vecs[3] = '{8'h01, 1, 0, 32'd2, 32'd2};
        vecs[4] = '{8'h80, 2, 2, 32'd3, 32'd2};

        PS_TDATA = 8'h00; PS_TVALID = 1'b0;
        RX_TDATA = '0; RX_TKEEP = '0; RX_TLAST = 1'b0; RX_TUSER = 1'b0; RX_TVALID = 1'b0;
        TX_TREADY = 1'b1;

        // Reset held four cycles, then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("ps_ready_in_reset", PS_TREADY, 1'b1);
        chk1("rx_ready_in_reset", RX_TREADY, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive();
        repeat (3) step();
        chk32("reset_good", good_packets, 32'd0);
        chk32("reset_bad", bad_packets, 32'd0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_tx_valid", TX_TVALID, 1'b0);
        chk1("reset_ps_ready", PS_TREADY, 1'b1);
        chk1("reset_tx_user", TX_TUSER, 1'b0);

        // Directed packet table, one packet at a time with full-rate timing checks.
        strict = 1;
        for (int v = 0; v < 5; v++) begin
            send(vecs[v].status, vecs[v].nbeats);
            run(200);
            chk32("vec_tx_beats", got_q.size(), vecs[v].exp_tx);
            compare_stream("vec");
            chk32("vec_good", good_packets, vecs[v].exp_good);
            chk32("vec_bad", bad_packets, vecs[v].exp_bad);
        end

        // Backpressure with ready toggling 1,0,0,1.
        strict = 0;
        tx_mode = 1;
        send(8'h00, 5);
        run(200);
        compare_stream("backpressure");
        chk32("bp_good", good_packets, exp_good);

        // Mixed back-to-back stream.
        strict = 1;
        tx_mode = 0;
        send(8'h00, 1); send(8'h01, 2); send(8'h00, 1); send(8'h01, 4); send(8'h01, 1);
        run(200);
        compare_stream("mixed");
        chk32("mixed_good", good_packets, exp_good);
        chk32("mixed_bad", bad_packets, exp_bad);

        // Randomized traffic with source gaps and random downstream ready.
        strict = 0;
        gaps = 1;
        tx_mode = 2;
        for (int p = 0; p < 25; p++) begin
            send(8'($urandom()), $urandom_range(1, 5));
        end
        run(3000);
        compare_stream("random");
        chk32("random_good", good_packets, exp_good);
        chk32("random_bad", bad_packets, exp_bad);

        // Good-counter saturation.
        gaps = 0;
        tx_mode = 0;
        force dut.good_cnt = 32'hFFFF_FFFE;
        mon_good = 32'hFFFF_FFFE;
        exp_good = 32'hFFFF_FFFE;
        step();
        release dut.good_cnt;
        step();
        send(8'h00, 1); send(8'h00, 2); send(8'h00, 1);
        run(200);
        compare_stream("saturate");
        chk32("saturate_good", good_packets, 32'hFFFF_FFFF);

        // Reset asserted during beat 2 of a 4-beat good packet.
        send(8'h00, 4);
        begin
            int n = 0;
            drive();
            while (got_q.size() < 1 && n < 20) begin
                step();
                n++;
            end
            chk32("midreset_first_beat", got_q.size(), 32'd1);
        end
        reset = 1'b1;
        ps_q.delete(); rx_q.delete(); exp_q.delete(); got_q.delete();
        mode = 0;
        drive();
        step();
        reset = 1'b0;
        exp_good = 32'd0; exp_bad = 32'd0; mon_good = 32'd0; mon_bad = 32'd0;
        have_end = 0; end_cyc = -10; first_pending = 0;
        drive();
        @(negedge clk);
        chk32("midreset_good", good_packets, 32'd0);
        chk32("midreset_bad", bad_packets, 32'd0);
        chk1("midreset_ps_ready", PS_TREADY, 1'b1);
        chk1("midreset_busy", busy, 1'b0);
        chk1("midreset_rx_ready", RX_TREADY, 1'b0);
        @(posedge clk);
        #1;
        send(8'h00, 2);
        run(200);
        compare_stream("after_reset");
        chk32("after_reset_good", good_packets, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/bpf_stage2.md
# bpf_stage2

Packet-drop controller for the bad-packet filter. It sits after the data FIFO and the packet-status FIFO that are fed by the stage-1 filter. For each packet it pops one status byte, then either forwards the packet's data beats to the output stream or silently drains them. It also keeps saturating good-packet and bad-packet counters.

## Interface
- DATA_WIDTH, 512, width of the packet data bus in bits; TKEEP width is DATA_WIDTH/8.
- clk  in  1  sole clock; every output and register is in this domain.
- reset  in  1  synchronous, active-high reset.
- AXIS_PS_TDATA  in  8  packet status from the status FIFO; bit 0: 0 = good, 1 = bad; bits 7:1 ignored.
- AXIS_PS_TVALID  in  1  status byte valid.
- AXIS_PS_TREADY  out  1  status byte accepted.
- AXIS_RX_TDATA / TKEEP / TLAST / TUSER  in  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  data beats from the data FIFO.
- AXIS_RX_TVALID  in  1  data beat valid.
- AXIS_RX_TREADY  out  1  data beat accepted.
- AXIS_TX_TDATA / TKEEP / TLAST  out  DATA_WIDTH / DATA_WIDTH/8 / 1  forwarded data beats.
- AXIS_TX_TUSER  out  1  constant 0; forwarded packets are good by construction.
- AXIS_TX_TVALID  out  1  forwarded beat valid.
- AXIS_TX_TREADY  in  1  downstream ready.
- good_packets  out  32  count of forwarded packets.
- bad_packets  out  32  count of dropped packets.
- busy  out  1  high while a packet is being forwarded or dropped.

## Operation
- FSM states: S_WAIT_STATUS, S_FORWARD, S_DROP.
- S_WAIT_STATUS:
  - Outputs: PS_TREADY = 1, RX_TREADY = 0, TX_TVALID = 0, busy = 0.
  - On a PS handshake (TVALID & TREADY): go to S_FORWARD if TDATA[0] = 0, else S_DROP.
- S_FORWARD:
  - Outputs: PS_TREADY = 0, TX_TVALID = RX_TVALID, RX_TREADY = TX_TREADY.
  - TX_TDATA, TX_TKEEP and TX_TLAST are driven combinationally from RX.
  - On a beat handshake with RX_TLAST = 1: good_packets += 1 and go to S_WAIT_STATUS.
- S_DROP:
  - Outputs: PS_TREADY = 0, RX_TREADY = 1, TX_TVALID = 0.
  - Each valid RX beat is consumed and discarded.
  - On RX_TVALID & RX_TLAST: bad_packets += 1 and go to S_WAIT_STATUS.
- RX_TUSER is ignored; the status byte alone decides forward or drop.
- Counters saturate at 0xFFFF_FFFF and never wrap.
- busy = 1 in S_FORWARD and S_DROP.
- A single-beat packet (TLAST on its first beat) is legal and completes in one data cycle.
- Only one status byte is consumed per packet. PS_TREADY is never high while a packet is in progress.

## Timing
- Reset values:
  - State = S_WAIT_STATUS.
  - Both counters = 0, busy = 0, PS_TREADY = 1 (it is asserted while reset is held).
  - RX_TREADY = 0, TX_TVALID = 0, TX_TUSER = 0.
- Reset asserted mid-packet: the FSM returns to S_WAIT_STATUS and both counters clear. The remaining beats of the in-flight packet are not tracked. Upstream FIFOs are reset by the same signal.
- Status to data latency: a PS handshake in cycle N causes the state change at the edge ending N. The first data beat can transfer in cycle N+1.
- No data beat transfers in the status cycle N.
- Packet end to next status: the last-beat handshake happens in cycle M. The next status byte can be accepted in cycle M+1.
- Minimum cost is therefore 1 dead cycle per packet.
- S_FORWARD adds zero latency. TX_TREADY backpressure passes straight through to RX_TREADY.
- Status arrives before data: the FSM waits in S_FORWARD or S_DROP indefinitely. No timeout.
- Data arrives before status: RX_TREADY stays 0 and data is held in the FIFO.
- Counter updates are visible on the cycle after the last-beat handshake.

## Test plan
- Reset then idle: hold reset 4 cycles, release, no traffic.
  - Required: counters 0, busy 0, TX_TVALID 0, PS_TREADY 1.
- Good packet: status 0x00, then 4 beats with TDATA = 1, 2, 3, 4, TLAST on beat 4, TX_TREADY held 1.
  - Required: TX carries exactly 1, 2, 3, 4 with TLAST on 4 and TUSER 0.
  - Required: good_packets = 1, and the next PS_TREADY rises the cycle after beat 4.
- Bad packet: status 0xFE|1 = 0xFF, then 3 beats.
  - Required: TX_TVALID never asserts, all 3 beats consumed at 1 per cycle.
  - Required: bad_packets = 1, good_packets unchanged.
- Backpressure: a good 5-beat packet with TX_TREADY toggling 1,0,0,1,…
  - Required: no beat lost or duplicated; RX_TREADY mirrors TX_TREADY cycle for cycle.
- Mixed stream: status sequence 0, 1, 0, 1, 1 with 1-beat, 2-beat, 1-beat, 4-beat and 1-beat packets, all arriving back to back.
  - Required: only packets 1 and 3 appear on TX; good = 2, bad = 3.
  - Required: exactly 1 idle cycle between packets.
- Saturation and mid-packet reset: preload good_packets to 0xFFFF_FFFE by force, send 3 good packets.
  - Required: the count sticks at 0xFFFF_FFFF.
  - Then assert reset during beat 2 of a 4-beat packet. Required: counters 0, state S_WAIT_STATUS, PS_TREADY 1 on the cycle after reset releases.
